// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one word per frame from an upstream FIFO and
// serialises it as start bit, DATA_WIDTH data bits (LSB first), stop bit.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  Read_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!empty) state <= REQ;
        end
        REQ: begin
          cnt   <= '0;
          idx   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          // FIFO read data is valid in this cycle, one after the pop request
          shreg <= data_out;
          cnt   <= '0;
          idx   <= '0;
          state <= START;
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore decode; reset forces state and so every output asynchronously
  assign Read_enable = (state == REQ);
  assign busy        = (state != IDLE);
  assign frame_done  = (state == STOP) && bit_end;

  always_comb begin
    tx = 1'b1;
    if (state == START) tx = 1'b0;
    else if (state == DATA) tx = shreg[0];
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model feeding the DUT, frame
// waveforms compared against a start/data/stop bit model and a vector table.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          empty = 1'b1;
  logic [DW-1:0] data_out = '0;
  logic          Read_enable;
  logic          tx;
  logic          busy;
  logic          frame_done;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .empty      (empty),
    .data_out   (data_out),
    .Read_enable(Read_enable),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic [9:0] frame;  // bit 0 goes out first: start, data LSB..MSB, stop
  } vec_t;

  vec_t        tab[5];
  logic [7:0]  fifo_q[$];
  bit          hold_empty = 1'b0;
  int unsigned cyc = 0;
  int          underflow = 0;
  int          tests = 0;
  int          failures = 0;

  // FIFO model: read data valid the cycle after a pop, garbage otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (Read_enable) begin
      if (fifo_q.size() > 0) data_out <= fifo_q.pop_front();
      else underflow <= underflow + 1;
    end else begin
      data_out <= 8'($urandom);
    end
    empty <= hold_empty || (fifo_q.size() == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] model_frame(input logic [7:0] w);
    return {1'b1, w, 1'b0};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_frame(input logic [7:0] w, input logic [9:0] exp_f,
                             input int max_wait, input bit drop_empty,
                             output int waited, output int start_cyc,
                             output int stop_cyc);
    logic [3:0] seen;
    int         fd_count;
    bit         fd_last;
    bit         got_re;
    bit         bad_ctrl;
    waited    = 0;
    start_cyc = 0;
    stop_cyc  = 0;
    fd_count  = 0;
    fd_last   = 1'b0;
    got_re    = 1'b0;
    bad_ctrl  = 1'b0;
    seen      = '0;
    while (!got_re && waited < max_wait) begin
      @(negedge clk);
      waited++;
      got_re = Read_enable;
    end
    if (!got_re) begin
      check($sformatf("read_enable_timeout_%02h", w), 32'(0), 32'(1));
      return;
    end
    @(negedge clk);
    check($sformatf("load_cycle_%02h", w), 32'({Read_enable, tx, busy, frame_done}), 32'(4'b0110));
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) begin
          start_cyc = int'(cyc);
          if (drop_empty) hold_empty = 1'b1;
        end
        seen[c] = tx;
        if (Read_enable || !busy) bad_ctrl = 1'b1;
        if (frame_done) begin
          fd_count++;
          fd_last = (b == 9 && c == CPB - 1);
        end
        if (b == 9 && c == CPB - 1) stop_cyc = int'(cyc);
      end
      check($sformatf("frame_%02h_bit%0d", w, b), 32'(seen), 32'({4{exp_f[b]}}));
    end
    check($sformatf("frame_%02h_ctrl", w), 32'(bad_ctrl), 32'(0));
    check($sformatf("frame_%02h_done_count", w), 32'(fd_count), 32'(1));
    check($sformatf("frame_%02h_done_last", w), 32'(fd_last), 32'(1));
    @(negedge clk);
    check($sformatf("frame_%02h_after_stop", w), 32'({busy, tx, frame_done}), 32'(3'b010));
  endtask

  task automatic idle_watch(input string nm, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (Read_enable || busy || !tx || frame_done) bad++;
    end
    check(nm, 32'(bad), 32'(0));
  endtask

  initial begin
    int         w, s, e, s1, e1, s2, e2, n, bad;
    logic [7:0] rw[2];

    tab[0] = '{word: 8'hA5, frame: 10'h34A};
    tab[1] = '{word: 8'h00, frame: 10'h200};
    tab[2] = '{word: 8'hFF, frame: 10'h3FE};
    tab[3] = '{word: 8'h3C, frame: 10'h278};
    tab[4] = '{word: 8'h81, frame: 10'h302};

    // Reset held with a word waiting
    reset = 1'b1;
    fifo_q.push_back(tab[0].word);
    idle_watch("reset_hold", 6);
    check("reset_empty_seen", 32'(empty), 32'(0));
    reset = 1'b0;

    // Single word, then the FIFO stays empty
    check_frame(tab[0].word, tab[0].frame, 2, 1'b0, w, s, e);
    check("single_len", 32'(e - s + 1), 32'(40));
    idle_watch("single_one_pop", 20);

    // Back-to-back 0x00, 0xFF
    fifo_q.push_back(tab[1].word);
    fifo_q.push_back(tab[2].word);
    check_frame(tab[1].word, tab[1].frame, 10, 1'b0, w, s1, e1);
    check_frame(tab[2].word, tab[2].frame, 1, 1'b0, w, s2, e2);
    check("b2b_gap_cycles", 32'(s2 - e1 - 1), 32'(3));
    idle_watch("b2b_idle", 10);

    // Table sweep, one word at a time
    for (int i = 0; i < 5; i++) begin
      fifo_q.push_back(tab[i].word);
      check_frame(tab[i].word, tab[i].frame, 10, 1'b0, w, s, e);
      check($sformatf("tab%0d_len", i), 32'(e - s + 1), 32'(40));
      repeat (i) @(negedge clk);
    end

    // Empty held high with a word sitting in the FIFO
    hold_empty = 1'b1;
    @(negedge clk);
    fifo_q.push_back(8'h77);
    idle_watch("empty_held", 100);
    fifo_q.delete();
    hold_empty = 1'b0;
    repeat (3) @(negedge clk);

    // Empty rises during START of 0x81: frame completes, no further pop
    fifo_q.push_back(tab[4].word);
    fifo_q.push_back(8'h42);
    check_frame(tab[4].word, tab[4].frame, 10, 1'b1, w, s, e);
    idle_watch("drop_empty_idle", 20);
    check("drop_empty_queue", 32'(fifo_q.size()), 32'(1));
    fifo_q.delete();
    hold_empty = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of 0x3C
    fifo_q.push_back(tab[3].word);
    n = 0;
    while (!Read_enable && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort_read_enable", 32'(Read_enable), 32'(1));
    @(negedge clk);
    repeat (4 + 3 * CPB + 1) @(negedge clk);
    check("abort_pre_reset", 32'({busy, tx}), 32'(2'b11));
    #1 reset = 1'b1;
    #1 check("abort_async", 32'({busy, tx, Read_enable, frame_done}), 32'(4'b0100));
    fifo_q.push_back(8'h5A);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || frame_done || Read_enable || !tx) bad++;
    end
    check("abort_reset_hold", 32'(bad), 32'(0));
    reset = 1'b0;
    check_frame(8'h5A, model_frame(8'h5A), 2, 1'b0, w, s, e);
    check("abort_req_latency_ok", 32'(w <= 2), 32'(1));

    // Randomized words, single or paired, against the frame model
    for (int k = 0; k < 8; k++) begin
      n = 1 + int'($urandom_range(0, 1));
      for (int j = 0; j < n; j++) begin
        rw[j] = 8'($urandom);
        fifo_q.push_back(rw[j]);
      end
      for (int j = 0; j < n; j++) begin
        check_frame(rw[j], model_frame(rw[j]), 12, 1'b0, w, s, e);
        check($sformatf("rand%0d_len", k), 32'(e - s + 1), 32'(40));
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    idle_watch("final_idle", 10);
    check("fifo_underflow_reads", 32'(underflow), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the FIFO word width and the number of serial data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit; legal range is 2 or greater.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port empty, input, 1 bit: the upstream FIFO's empty flag.
REQ-006 SHALL have port data_out, input, DATA_WIDTH bits: the FIFO read data, valid in the cycle after the FIFO samples Read_enable=1.
REQ-007 SHALL have port Read_enable, output, 1 bit: pop request to the FIFO.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse in the last cycle of the stop bit.

Function
REQ-011 SHALL implement the states IDLE, REQ, LOAD, START, DATA and STOP.
REQ-012 SHALL have Moore outputs only, decoded from registered state and counters; Read_enable = (state==REQ).
REQ-013 In IDLE, SHALL go to REQ if empty=0 and stay in IDLE otherwise.
REQ-014 SHALL move REQ -> LOAD unconditionally, so Read_enable is exactly one cycle wide per frame.
REQ-015 In LOAD, SHALL capture data_out into a DATA_WIDTH shift register and go to START.
REQ-016 In START, SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 In DATA, SHALL drive tx = shift register bit 0 (LSB first), with each bit held CLKS_PER_BIT cycles, a shift after each bit, and DATA_WIDTH bits in total; then go to STOP.
REQ-018 In STOP, SHALL drive tx=1 for CLKS_PER_BIT cycles, pulse frame_done in its final cycle, then go to IDLE.
REQ-019 SHALL drive tx=1 in IDLE, REQ and LOAD.
REQ-020 SHALL use a bit-period counter of $clog2(CLKS_PER_BIT) bits running 0..CLKS_PER_BIT-1, and a bit-index counter of $clog2(DATA_WIDTH)+1 bits; both clear on every state entry.
REQ-021 SHALL give a frame length, START entry to STOP exit, of exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-022 For back-to-back frames with empty=0, SHALL hold tx=1 for exactly 3 cycles (IDLE, REQ, LOAD) between a stop bit and the next start bit.
REQ-023 SHALL never assert Read_enable unless empty was 0 in the preceding IDLE cycle.
REQ-024 SHALL ignore empty outside IDLE; a change mid-frame does not alter the frame in progress.
REQ-025 SHALL not re-sample data_out after LOAD; later changes on data_out do not affect the frame.

Reset
REQ-026 While reset=1, SHALL force, asynchronously: state=IDLE, tx=1, busy=0, Read_enable=0, frame_done=0, counters=0, shift register=0.
REQ-027 On reset mid-frame, SHALL abort the frame immediately with no partial stop bit and no frame_done; the popped word is discarded.
REQ-028 After reset deasserts, SHALL evaluate empty on the first rising edge in IDLE.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-029 Bench SHALL cover: reset=1 with empty=0 -> tx=1, busy=0, Read_enable=0 throughout.
REQ-030 Bench SHALL cover: single word 0xA5 with empty=0 then empty=1 -> one Read_enable pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles); frame_done once.
REQ-031 Bench SHALL cover: words 0x00 then 0xFF queued -> two Read_enable pulses; exactly 3 tx-high cycles between the first stop bit and the second start bit.
REQ-032 Bench SHALL cover: empty held 1 for 100 cycles -> Read_enable never asserted, tx=1, busy=0.
REQ-033 Bench SHALL cover: reset asserted during data bit 3 of 0x3C -> tx=1 and busy=0 in the same cycle, no frame_done; after release with empty=0, a new REQ follows within 2 cycles.
REQ-034 Bench SHALL cover: empty rises from 0 to 1 during START of 0x81 -> frame completes fully, no further Read_enable, return to IDLE.
